// File: rtl/spi_pkg.sv
// Shared SPI definitions: responder state encoding, SCK edge-to-strobe decode
// for the CPOL/CPHA mode, and the minimum SCK oversampling ratio.
`timescale 1ns/1ps
package spi_pkg;

    localparam int MIN_OVERSAMPLE = 8;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_ACTIVE   = 2'd2
    } spi_state_e;

    typedef struct packed {
        logic sample;
        logic shift;
    } spi_strobe_t;

    // Leading edge is the first transition away from the CPOL idle level.
    function automatic spi_strobe_t spi_decode_strobes(
        input logic cpol,
        input logic cpha,
        input logic sck_rise,
        input logic sck_fall
    );
        logic        leading;
        logic        trailing;
        spi_strobe_t strb;
        leading     = cpol ? sck_fall : sck_rise;
        trailing    = cpol ? sck_rise : sck_fall;
        strb.sample = cpha ? trailing : leading;
        strb.shift  = cpha ? leading  : trailing;
        return strb;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus a history flop, giving
// the synchronized level and single-cycle rise/fall strobes.
`timescale 1ns/1ps
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic Clk_I,
    input  logic RstP_I,
    input  logic Async_I,
    output logic Sync_O,
    output logic Rise_O,
    output logic Fall_O
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    // NOTE: flops are written with <= so every stage samples the previous
    // stage's old value; blocking assignments would collapse the chain.
    always_ff @(posedge Clk_I) begin
        if (RstP_I) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            hist_q <= RESET_VAL;
        end else begin
            meta_q <= Async_I;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign Sync_O = sync_q;
    assign Rise_O = sync_q & ~hist_q;
    assign Fall_O = ~sync_q & hist_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder running in the system clock domain: oversamples SCK/CS_N/MOSI,
// receives full-duplex words and transmits from a single-entry holding register.
`timescale 1ns/1ps
module spi_slave
    import spi_pkg::*;
#(
    parameter int   CLK_FREQ     = 50,
    parameter int   SPI_CLK_FREQ = 1000,
    parameter logic CPOL         = 1'b0,
    parameter logic CPHA         = 1'b0,
    parameter int   DATA_WIDTH   = 8,
    parameter logic MSB_FIRST    = 1'b1
) (
    input  logic                  Clk_I,
    input  logic                  RstP_I,
    input  logic                  SCK_I,
    input  logic                  CS_N_I,
    input  logic                  MOSI_I,
    output logic                  MISO_O,
    output logic                  MISOOe_O,
    input  logic [DATA_WIDTH-1:0] TxData_I,
    input  logic                  TxValid_I,
    output logic                  TxReady_O,
    output logic [DATA_WIDTH-1:0] RxData_O,
    output logic                  RxValid_O,
    output logic                  TxUnderrun_O,
    output logic                  Busy_O
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    if (CLK_FREQ * 1000 / SPI_CLK_FREQ < MIN_OVERSAMPLE) begin : g_oversample_check
        $error("spi_slave: system clock must be at least %0d x SCK", MIN_OVERSAMPLE);
    end
    if (DATA_WIDTH < 4 || DATA_WIDTH > 32) begin : g_width_check
        $error("spi_slave: DATA_WIDTH must be within 4..32");
    end

    // Pin synchronizers
    logic sck_level_unused;
    logic sck_rise;
    logic sck_fall;
    logic cs_level;
    logic cs_rise;
    logic cs_fall;
    logic mosi_meta_q;
    logic mosi_sync_q;

    spi_sync_edge #(.RESET_VAL(CPOL)) u_sck_sync (
        .Clk_I   (Clk_I),
        .RstP_I  (RstP_I),
        .Async_I (SCK_I),
        .Sync_O  (sck_level_unused),
        .Rise_O  (sck_rise),
        .Fall_O  (sck_fall)
    );

    // CS_N resets to "selected" so a reset in mid-frame can only re-arm after
    // the pin is genuinely seen high.
    spi_sync_edge #(.RESET_VAL(1'b0)) u_cs_sync (
        .Clk_I   (Clk_I),
        .RstP_I  (RstP_I),
        .Async_I (CS_N_I),
        .Sync_O  (cs_level),
        .Rise_O  (cs_rise),
        .Fall_O  (cs_fall)
    );

    always_ff @(posedge Clk_I) begin
        if (RstP_I) begin
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            mosi_meta_q <= MOSI_I;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    // State machine
    spi_state_e state_q;
    spi_state_e state_d;

    always_ff @(posedge Clk_I) begin
        if (RstP_I) begin
            state_q <= ST_DISARMED;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_DISARMED: if (cs_level) state_d = ST_IDLE;
            ST_IDLE:     if (cs_fall)  state_d = ST_ACTIVE;
            ST_ACTIVE:   if (cs_rise)  state_d = ST_IDLE;
            default:                   state_d = ST_DISARMED;
        endcase
    end

    // Datapath control
    spi_strobe_t           strb;
    logic                  start_word;
    logic                  active;
    logic                  sample_en;
    logic                  shift_en;
    logic                  last_bit;
    logic                  reload;
    logic                  tx_accept;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  hold_full_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] rx_shift_q;
    logic [DATA_WIDTH-1:0] rx_word_next;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  underrun_q;
    logic                  ur_pending_q;
    logic [CNT_W-1:0]      bit_cnt_q;

    assign strb       = spi_decode_strobes(CPOL, CPHA, sck_rise, sck_fall);
    assign start_word = (state_q == ST_IDLE) && cs_fall;
    assign active     = (state_q == ST_ACTIVE) && !cs_rise;
    assign sample_en  = active && strb.sample;
    // The edge that would shift bit 0 of a word away is dropped in both phases:
    // for CPHA=1 it is the first leading edge, for CPHA=0 the trailing edge
    // that follows the previous word's final sample (and the reload).
    assign shift_en   = active && strb.shift && (bit_cnt_q != '0);
    assign last_bit   = sample_en && (bit_cnt_q == LAST_BIT);
    assign reload     = start_word || last_bit;
    assign tx_accept  = TxValid_I && !hold_full_q;

    assign rx_word_next = MSB_FIRST ? {rx_shift_q[DATA_WIDTH-2:0], mosi_sync_q}
                                    : {mosi_sync_q, rx_shift_q[DATA_WIDTH-1:1]};

    // NOTE: every register here, holding register included, is reset: there is
    // no RAM-style storage, and reset values are visible on the ports.
    always_ff @(posedge Clk_I) begin
        if (RstP_I) begin
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shift_q      <= '0;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            underrun_q   <= 1'b0;
            ur_pending_q <= 1'b0;
            bit_cnt_q    <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;

            // Accept only while empty and reload only while full: never both.
            if (tx_accept) begin
                hold_q      <= TxData_I;
                hold_full_q <= 1'b1;
            end else if (reload && hold_full_q) begin
                hold_full_q <= 1'b0;
            end

            if (start_word) begin
                bit_cnt_q <= '0;
            end else if (sample_en) begin
                bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
            end

            if (sample_en) begin
                rx_shift_q <= rx_word_next;
            end
            if (last_bit) begin
                rx_data_q  <= rx_word_next;
                rx_valid_q <= 1'b1;
            end

            if (reload) begin
                shift_q <= hold_full_q ? hold_q : '0;
            end else if (shift_en) begin
                shift_q <= MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
            end

            // An empty reload is flagged only once the word really starts, so a
            // frame that ends right after its last word reports nothing extra.
            if (reload) begin
                ur_pending_q <= !hold_full_q;
            end else if (!active) begin
                ur_pending_q <= 1'b0;
            end else if (sample_en && (bit_cnt_q == '0)) begin
                ur_pending_q <= 1'b0;
                underrun_q   <= ur_pending_q;
            end
        end
    end

    assign MISO_O       = (state_q == ST_ACTIVE) ? (MSB_FIRST ? shift_q[DATA_WIDTH-1] : shift_q[0])
                                                 : 1'b0;
    assign MISOOe_O     = (state_q == ST_ACTIVE);
    assign Busy_O       = (state_q == ST_ACTIVE);
    assign TxReady_O    = !hold_full_q;
    assign RxData_O     = rx_data_q;
    assign RxValid_O    = rx_valid_q;
    assign TxUnderrun_O = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: four 8-bit instances (one per CPOL/CPHA mode)
// and one 16-bit LSB-first instance at SCK = CLK/8, driven by a bit-bang master.
`timescale 1ns/1ps
module tb_spi_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck      [5];
    logic        cs_n     [5];
    logic        mosi;
    logic        miso     [5];
    logic        miso_oe  [5];
    logic        tx_valid [5];
    logic        tx_ready [5];
    logic        rx_valid [5];
    logic        underrun [5];
    logic        busy     [5];
    logic [7:0]  tx_data8;
    logic [7:0]  rx_data8 [4];
    logic [15:0] tx_data16;
    logic [15:0] rx_data16;

    int n_cmp  = 0;
    int n_fail = 0;

    always #10 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        spi_slave #(
            .CLK_FREQ     (50),
            .SPI_CLK_FREQ (1000),
            .CPOL         ((k >= 2) ? 1'b1 : 1'b0),
            .CPHA         ((k % 2 == 1) ? 1'b1 : 1'b0),
            .DATA_WIDTH   (8),
            .MSB_FIRST    (1'b1)
        ) u_dut (
            .Clk_I        (clk),
            .RstP_I       (rst),
            .SCK_I        (sck[k]),
            .CS_N_I       (cs_n[k]),
            .MOSI_I       (mosi),
            .MISO_O       (miso[k]),
            .MISOOe_O     (miso_oe[k]),
            .TxData_I     (tx_data8),
            .TxValid_I    (tx_valid[k]),
            .TxReady_O    (tx_ready[k]),
            .RxData_O     (rx_data8[k]),
            .RxValid_O    (rx_valid[k]),
            .TxUnderrun_O (underrun[k]),
            .Busy_O       (busy[k])
        );
    end

    spi_slave #(
        .CLK_FREQ     (50),
        .SPI_CLK_FREQ (6250),
        .CPOL         (1'b0),
        .CPHA         (1'b0),
        .DATA_WIDTH   (16),
        .MSB_FIRST    (1'b0)
    ) u_dut16 (
        .Clk_I        (clk),
        .RstP_I       (rst),
        .SCK_I        (sck[4]),
        .CS_N_I       (cs_n[4]),
        .MOSI_I       (mosi),
        .MISO_O       (miso[4]),
        .MISOOe_O     (miso_oe[4]),
        .TxData_I     (tx_data16),
        .TxValid_I    (tx_valid[4]),
        .TxReady_O    (tx_ready[4]),
        .RxData_O     (rx_data16),
        .RxValid_O    (rx_valid[4]),
        .TxUnderrun_O (underrun[4]),
        .Busy_O       (busy[4])
    );

    // Pulse monitor: counts RxValid/TxUnderrun strobes and logs received words.
    logic [7:0]  rx_log [4][4];
    int          rx_cnt [5] = '{0, 0, 0, 0, 0};
    int          ur_cnt [5] = '{0, 0, 0, 0, 0};
    logic [15:0] rx16_last = 16'h0;

    always @(posedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (rx_valid[k] === 1'b1) begin
                rx_cnt[k] <= rx_cnt[k] + 1;
                if (k < 4) rx_log[k][rx_cnt[k] % 4] <= rx_data8[k];
                else       rx16_last <= rx_data16;
            end
            if (underrun[k] === 1'b1) ur_cnt[k] <= ur_cnt[k] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic mode_cpol(input int idx);
        return (idx == 2) || (idx == 3);
    endfunction

    function automatic logic mode_cpha(input int idx);
        return (idx == 1) || (idx == 3);
    endfunction

    function automatic int half_of(input int idx);
        return (idx == 4) ? 4 : 25;
    endfunction

    task automatic push(input int idx, input logic [15:0] d);
        tx_data8     = d[7:0];
        tx_data16    = d;
        tx_valid[idx] = 1'b1;
        wait_clk(1);
        tx_valid[idx] = 1'b0;
    endtask

    task automatic cs_low(input int idx);
        cs_n[idx] = 1'b0;
        wait_clk(half_of(idx));
    endtask

    task automatic cs_high(input int idx);
        wait_clk(half_of(idx));
        cs_n[idx] = 1'b1;
        wait_clk(half_of(idx));
    endtask

    // Master side: shifts nbits of tx out on MOSI and captures MISO into rx.
    task automatic spi_word(input int idx, input int nbits, input logic [31:0] tx,
                            output logic [31:0] rx);
        logic        cpol;
        logic        cpha;
        logic        lsb;
        logic        b;
        logic        m;
        int          half;
        logic [31:0] r;
        cpol = mode_cpol(idx);
        cpha = mode_cpha(idx);
        lsb  = (idx == 4);
        half = half_of(idx);
        r    = '0;
        for (int i = 0; i < nbits; i++) begin
            b = lsb ? tx[i] : tx[nbits-1-i];
            if (!cpha) begin
                mosi = b;
                wait_clk(half);
                m = miso[idx];
                sck[idx] = ~cpol;
                wait_clk(half);
                sck[idx] = cpol;
            end else begin
                sck[idx] = ~cpol;
                mosi = b;
                wait_clk(half);
                m = miso[idx];
                sck[idx] = cpol;
                wait_clk(half);
            end
            if (lsb) r[i] = m;
            else     r[nbits-1-i] = m;
        end
        rx = r;
    endtask

    initial begin
        logic [31:0] g0;
        logic [31:0] g1;
        int          base_rx;
        int          base_ur;

        rst       = 1'b1;
        mosi      = 1'b0;
        tx_data8  = 8'h0;
        tx_data16 = 16'h0;
        for (int k = 0; k < 5; k++) begin
            sck[k]      = mode_cpol(k);
            cs_n[k]     = 1'b1;
            tx_valid[k] = 1'b0;
        end
        wait_clk(3);

        check("rst_miso",     32'(miso[0]),     32'h0);
        check("rst_miso_oe",  32'(miso_oe[0]),  32'h0);
        check("rst_tx_ready", 32'(tx_ready[0]), 32'h1);
        check("rst_rx_data",  32'(rx_data8[0]), 32'h0);
        check("rst_rx_valid", 32'(rx_valid[0]), 32'h0);
        check("rst_underrun", 32'(underrun[0]), 32'h0);
        check("rst_busy",     32'(busy[0]),     32'h0);
        rst = 1'b0;
        wait_clk(6);

        // Mode 0 single word: preload 0xA5, master sends 0x3C.
        push(0, 16'h00A5);
        check("t1_tx_ready_low", 32'(tx_ready[0]), 32'h0);
        base_rx = rx_cnt[0];
        base_ur = ur_cnt[0];
        cs_low(0);
        check("t1_busy",    32'(busy[0]),    32'h1);
        check("t1_miso_oe", 32'(miso_oe[0]), 32'h1);
        spi_word(0, 8, 32'h3C, g0);
        cs_high(0);
        check("t1_rx_pulses", 32'(rx_cnt[0] - base_rx), 32'h1);
        check("t1_rx_data",   32'(rx_data8[0]),         32'h3C);
        check("t1_master_rx", g0,                       32'hA5);
        check("t1_tx_ready",  32'(tx_ready[0]),         32'h1);
        check("t1_underrun",  32'(ur_cnt[0] - base_ur), 32'h0);
        check("t1_idle_busy", 32'(busy[0]),             32'h0);

        // All four modes: two back-to-back words under one CS.
        for (int k = 0; k < 4; k++) begin
            push(k, 16'h0055);
            base_rx = rx_cnt[k];
            base_ur = ur_cnt[k];
            cs_low(k);
            push(k, 16'h00AA);
            spi_word(k, 8, 32'h81, g0);
            spi_word(k, 8, 32'h7E, g1);
            cs_high(k);
            check($sformatf("mode%0d_rx_pulses", k), 32'(rx_cnt[k] - base_rx), 32'h2);
            check($sformatf("mode%0d_rx_word0", k), 32'(rx_log[k][base_rx % 4]), 32'h81);
            check($sformatf("mode%0d_rx_word1", k), 32'(rx_log[k][(base_rx + 1) % 4]), 32'h7E);
            check($sformatf("mode%0d_miso_word0", k), g0, 32'h55);
            check($sformatf("mode%0d_miso_word1", k), g1, 32'hAA);
            check($sformatf("mode%0d_underrun", k), 32'(ur_cnt[k] - base_ur), 32'h0);
        end

        // Underrun: no preload.
        base_ur = ur_cnt[0];
        cs_low(0);
        check("ur_tx_ready_mid", 32'(tx_ready[0]), 32'h1);
        spi_word(0, 8, 32'h5A, g0);
        cs_high(0);
        check("ur_pulses",    32'(ur_cnt[0] - base_ur), 32'h1);
        check("ur_master_rx", g0,                       32'h0);
        check("ur_tx_ready",  32'(tx_ready[0]),         32'h1);
        check("ur_rx_data",   32'(rx_data8[0]),         32'h5A);

        // CS_N raised after 5 bits, holding register refilled mid-frame.
        push(0, 16'h0011);
        cs_low(0);
        push(0, 16'h0022);
        base_rx = rx_cnt[0];
        spi_word(0, 5, 32'h1F, g0);
        cs_high(0);
        check("abort_rx_pulses", 32'(rx_cnt[0] - base_rx), 32'h0);
        check("abort_rx_held",   32'(rx_data8[0]),         32'h5A);
        check("abort_hold_full", 32'(tx_ready[0]),         32'h0);
        cs_low(0);
        spi_word(0, 8, 32'hC3, g0);
        cs_high(0);
        check("abort_next_pulses", 32'(rx_cnt[0] - base_rx), 32'h1);
        check("abort_next_rx",     32'(rx_data8[0]),         32'hC3);
        check("abort_next_miso",   g0,                       32'h22);

        // Reset at bit 3 with CS_N still low.
        base_rx = rx_cnt[0];
        cs_low(0);
        spi_word(0, 3, 32'h5, g0);
        rst = 1'b1;
        wait_clk(1);
        check("midrst_miso",     32'(miso[0]),     32'h0);
        check("midrst_miso_oe",  32'(miso_oe[0]),  32'h0);
        check("midrst_busy",     32'(busy[0]),     32'h0);
        check("midrst_rx_data",  32'(rx_data8[0]), 32'h0);
        check("midrst_tx_ready", 32'(tx_ready[0]), 32'h1);
        rst = 1'b0;
        spi_word(0, 5, 32'h1A, g0);
        wait_clk(4);
        check("midrst_ignored_busy", 32'(busy[0]),             32'h0);
        check("midrst_ignored_rx",   32'(rx_cnt[0] - base_rx), 32'h0);
        cs_high(0);
        cs_low(0);
        spi_word(0, 8, 32'h96, g0);
        cs_high(0);
        check("midrst_next_pulses", 32'(rx_cnt[0] - base_rx), 32'h1);
        check("midrst_next_rx",     32'(rx_data8[0]),         32'h96);
        check("midrst_next_miso",   g0,                       32'h0);

        // 16-bit LSB first at SCK = CLK/8.
        push(4, 16'hC0DE);
        base_rx = rx_cnt[4];
        cs_low(4);
        spi_word(4, 16, 32'h1234, g0);
        cs_high(4);
        check("w16_rx_pulses", 32'(rx_cnt[4] - base_rx), 32'h1);
        check("w16_rx_data",   32'(rx_data16),           32'h1234);
        check("w16_rx_logged", 32'(rx16_last),           32'h1234);
        check("w16_master_rx", g0,                       32'hC0DE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
